// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: two-flop input synchroniser, false-start
// rejection, runtime parity/stop-bit selection, parity/framing/break flags
// and a valid/ready holding register with sticky overrun.
module uart_rx_ovs #(
  parameter int DATA_WIDTH = 8,
  parameter int OVS        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  s_tick,
  input  logic [1:0]            parity_mode,
  input  logic                  stop_bits,
  input  logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  break_det,
  output logic                  overrun,
  output logic                  busy
);

  localparam int TICK_W = $clog2(OVS) + 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH);
  localparam logic [TICK_W-1:0] HALF_M1  = TICK_W'(OVS / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_M1  = TICK_W'(OVS - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  // Parity check: mode 01 expects even overall parity, 10 odd; others disable.
  function automatic logic parity_fail(input logic [DATA_WIDTH-1:0] d,
                                       input logic pb,
                                       input logic [1:0] mode);
    logic x;
    x = (^d) ^ pb;
    case (mode)
      2'b01:   parity_fail = x;
      2'b10:   parity_fail = ~x;
      default: parity_fail = 1'b0;
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic                    sync1_q, sync1_d;
  logic                    sync2_q, sync2_d;
  logic [TICK_W-1:0]       tick_q, tick_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [1:0]              pmode_q, pmode_d;
  logic                    stop2_q, stop2_d;
  logic                    pbit_q, pbit_d;
  logic                    stop1_q, stop1_d;
  // Cleared when a frame ends on a low stop sample (e.g. a break) so that a
  // line still held low is not mistaken for a new start bit.
  logic                    arm_q, arm_d;

  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    parity_err_q, parity_err_d;
  logic                    frame_err_q, frame_err_d;
  logic                    break_det_q, break_det_d;
  logic                    overrun_q, overrun_d;

  logic                    rx_s;
  logic                    par_en;
  logic                    complete;
  logic                    first_stop;
  logic                    last_stop;
  logic                    new_perr;
  logic                    new_ferr;
  logic                    new_brk;

  assign rx_s   = sync2_q;
  assign par_en = (pmode_q == 2'b01) || (pmode_q == 2'b10);

  // Synchroniser next values.
  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
  end

  // Receive FSM: next state, bit timing and frame assembly.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    pmode_d    = pmode_q;
    stop2_d    = stop2_q;
    pbit_d     = pbit_q;
    stop1_d    = stop1_q;
    arm_d      = arm_q | rx_s;
    complete   = 1'b0;
    first_stop = 1'b1;
    last_stop  = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!rx_s && arm_q) begin
          tick_d  = '0;
          pmode_d = parity_mode;
          stop2_d = stop_bits;
          state_d = S_START;
        end
      end
      S_START: begin
        if (s_tick) begin
          if (tick_q == HALF_M1) begin
            if (rx_s) begin
              state_d = S_IDLE;
            end else begin
              tick_d  = '0;
              bit_d   = '0;
              state_d = S_DATA;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      S_DATA: begin
        if (s_tick) begin
          if (tick_q == FULL_M1) begin
            tick_d  = '0;
            shreg_d = {rx_s, shreg_q[DATA_WIDTH-1:1]};
            if (bit_q == LAST_BIT) begin
              state_d = par_en ? S_PARITY : S_STOP1;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (s_tick) begin
          if (tick_q == FULL_M1) begin
            tick_d  = '0;
            pbit_d  = rx_s;
            state_d = S_STOP1;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      S_STOP1: begin
        if (s_tick) begin
          if (tick_q == FULL_M1) begin
            tick_d  = '0;
            stop1_d = rx_s;
            if (stop2_q) begin
              state_d = S_STOP2;
            end else begin
              complete   = 1'b1;
              first_stop = rx_s;
              last_stop  = rx_s;
              state_d    = S_IDLE;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      S_STOP2: begin
        if (s_tick) begin
          if (tick_q == FULL_M1) begin
            tick_d     = '0;
            complete   = 1'b1;
            first_stop = stop1_q;
            last_stop  = rx_s;
            state_d    = S_IDLE;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (complete && !last_stop) begin
      arm_d = 1'b0;
    end
  end

  // Flags for the frame completing this cycle.
  always_comb begin
    new_perr = par_en & parity_fail(shreg_q, pbit_q, pmode_q);
    new_ferr = ~first_stop | ~last_stop;
    new_brk  = (shreg_q == '0) & (~par_en | ~pbit_q) & ~first_stop;
  end

  // Holding register: load on completion when free or being accepted, else overrun.
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    break_det_d  = break_det_q;
    overrun_d    = overrun_q;
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
    if (complete) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shreg_q;
        parity_err_d = new_perr;
        frame_err_d  = new_ferr;
        break_det_d  = new_brk;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State, datapath and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      tick_q       <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      pmode_q      <= 2'b00;
      stop2_q      <= 1'b0;
      pbit_q       <= 1'b0;
      stop1_q      <= 1'b1;
      arm_q        <= 1'b1;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      pmode_q      <= pmode_d;
      stop2_q      <= stop2_d;
      pbit_q       <= pbit_d;
      stop1_q      <= stop1_d;
      arm_q        <= arm_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_det_q  <= break_det_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign break_det  = break_det_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_ovs.md
Name: uart_rx_ovs

Overview:
- Second-generation oversampling UART receiver for the serial I/O subsystem.
- Generalises the single-mode receiver with:
  - parametrised data width and oversampling ratio
  - runtime parity and stop-bit selection
  - input synchronisation and false-start rejection
  - parity, framing and break error reporting
  - a valid/ready output holding register with overrun detection.
- Sits between the shared baud-tick generator and the RX FIFO or CPU register interface.

Parameters:
DATA_WIDTH, 8, payload bits per frame; legal range 5..9.
OVS, 16, s_tick pulses per bit period; must be even and at least 8.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx  input  1  raw serial line; asynchronous; idles high
s_tick  input  1  oversampling enable, one-clk pulse, OVS pulses per bit
parity_mode  input  2  00 none, 01 even, 10 odd, 11 none
stop_bits  input  1  0: one stop bit, 1: two stop bits
rx_ready  input  1  consumer accepts the held word
rx_data  output  DATA_WIDTH  received payload, LSB first on the line
rx_valid  output  1  rx_data and its flags are valid
parity_err  output  1  parity mismatch for the held word
frame_err  output  1  a stop bit sampled low for the held word
break_det  output  1  all data bits, parity (if enabled) and the first stop bit sampled low
overrun  output  1  sticky: at least one frame was dropped while rx_valid was high
busy  output  1  high in any state other than IDLE

Behaviour:
Reset (async, active-low):
- State goes to IDLE and all counters clear.
- rx_data=0; rx_valid, parity_err, frame_err, break_det, overrun, busy = 0.
- Synchroniser flops are set to 1.
- Reset mid-frame abandons the frame with no output update.

Synchroniser:
- rx passes through 2 flops to give rx_s. All decisions use rx_s.

Config capture:
- parity_mode and stop_bits are latched on the IDLE->START transition.
- Changes mid-frame have no effect on the frame in progress.

Tick counter:
- Width clog2(OVS)+1 bits.
- Advances only on cycles with s_tick=1.

States:
- IDLE: on rx_s=0, clear the tick counter and go to START.
- START:
  - On the tick where the counter reaches OVS/2-1, sample rx_s.
  - If rx_s=1, treat as a false start: go to IDLE with no output change.
  - If rx_s=0, clear the tick counter and bit counter, then go to DATA.
- DATA:
  - On the tick where the counter reaches OVS-1 (bit centre), shift rx_s into bit[bit counter] and clear the tick counter.
  - After bit DATA_WIDTH-1, go to PARITY if parity is enabled, otherwise STOP1.
- PARITY:
  - Sample at the centre (same rule as DATA).
  - Even mode: error if XOR(data, parity bit) = 1.
  - Odd mode: error if XOR(data, parity bit) = 0.
- STOP1:
  - Sample at the centre.
  - If stop_bits=1, go to STOP2. Otherwise complete the frame.
- STOP2: sample at the centre, then complete the frame.
- frame_err is set if any stop sample is 0.

Frame completion:
- Occurs in the clk cycle of the final stop-bit sample tick; outputs update on the next edge.
- State returns to IDLE at the stop-bit centre, so the next falling edge is detected immediately.

Output register update on completion:
- If rx_valid=0, or rx_ready=1 in the same cycle: load rx_data, parity_err, frame_err and break_det, and set rx_valid=1.
- Otherwise: drop the new frame, leave the held word unchanged, and set overrun=1.

Handshake:
- rx_valid stays high until a cycle with rx_valid=1 and rx_ready=1. rx_valid clears on the next edge unless a frame completes in that same cycle.
- rx_ready while rx_valid=0 is ignored.
- overrun clears on a successful accept (rx_valid & rx_ready).
- A drop in the same cycle as an accept cannot occur; completion and accept in the same cycle count as a load.

Timing rules:
- s_tick=0 freezes the receiver; a missing tick only stretches timing.
- Latency: rx_valid rises 1 clk after the final stop-bit centre tick.
- No rx_done-style pulse is produced; consumers use rx_valid/rx_ready.

Test Plan:
1. 8N1, OVS=16, send 0xA5 then 0x3C with rx_ready held 1 -> rx_valid pulses twice; rx_data = 0xA5, then 0x3C; all error flags 0.
2. Even parity, send 0x07 with parity bit 0 -> parity_err=1. Resend with parity bit 1 -> parity_err=0. Odd mode, 0x07 with parity bit 0 -> parity_err=0.
3. 2 stop bits, second stop bit driven low -> frame_err=1, rx_data correct. Line held low for 12 bit times -> break_det=1 and frame_err=1; no second frame until rx_s returns high and falls again.
4. rx low for 4 ticks then high (glitch) -> state returns to IDLE, busy drops, rx_valid stays 0. Then a valid 0x55 frame is received correctly.
5. rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun=1. Assert rx_ready one cycle -> rx_valid=0, overrun=0. Next frame 0x33 loads normally.
6. Assert reset during DATA bit 4 of a frame -> all outputs 0 immediately. After release, a new frame 0x81 is received correctly; DATA_WIDTH=5 and OVS=8 build repeats scenario 1 with 0x15.
